n_subtractor_serial: RTL and testbench
======================================

N_SUBTRACTOR_SERIAL -- requirements
Module: n_subtractor_serial

Interface
REQ-001 Parameter: N, default 8, operand/result width in bits; SHALL be >= 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rstn  input  1  asynchronous, active-low reset.
REQ-004 s_valid  input  1  operand set on A, B, b_in is valid.
REQ-005 s_ready  output  1  block can accept an operand set.
REQ-006 A  input  N  minuend, two's complement or unsigned.
REQ-007 B  input  N  subtrahend, two's complement or unsigned.
REQ-008 b_in  input  1  borrow-in, subtracted at bit 0.
REQ-009 m_valid  output  1  result on D, b_out, ovf is valid.
REQ-010 m_ready  input  1  consumer accepts result.
REQ-011 D  output  N  difference, A - B - b_in modulo 2^N.
REQ-012 b_out  output  1  unsigned borrow-out: 1 iff A < B + b_in (unsigned).
REQ-013 ovf  output  1  signed overflow of A - B - b_in.

Function
REQ-014 FSM states SHALL be IDLE, BUSY and DONE.
REQ-015 IDLE: s_ready=1, m_valid=0; s_valid=1 at a rising edge SHALL capture A, B, b_in into internal registers, clear the bit counter and move to BUSY.
REQ-016 Input changes after the accepting edge SHALL NOT affect the result.
REQ-017 BUSY: s_ready=0, m_valid=0; one bit per cycle, LSB first, for exactly N cycles.
REQ-018 Per-bit rule: d = a XOR b XOR bw; bw_next = (NOT a AND b) OR (NOT(a XOR b) AND bw); bw initialised to b_in.
REQ-019 The bit counter SHALL count 0..N-1; after the bit-(N-1) edge the FSM SHALL enter DONE.
REQ-020 Latency: s_valid accepted at edge k gives m_valid=1 after edge k+N.
REQ-021 DONE: m_valid=1, s_ready=0; D, b_out and ovf SHALL be stable until the handshake.
REQ-022 DONE with m_ready=1 at a rising edge SHALL complete the transfer and return to IDLE; m_valid drops after that edge.
REQ-023 DONE with m_ready=0 SHALL hold DONE indefinitely with all outputs unchanged.
REQ-024 No operand is accepted in BUSY or DONE (s_ready=0); max throughput is one operation per N+2 cycles.
REQ-025 b_out SHALL equal the final bw.
REQ-026 ovf SHALL be (A[N-1] != B[N-1]) AND (D[N-1] != A[N-1]), using the captured A and B.
REQ-027 D, b_out and ovf SHALL retain the last result in IDLE until the next DONE; values outside DONE are not qualified.
REQ-028 m_ready asserted outside DONE SHALL be ignored.

Reset
REQ-029 rstn=0 SHALL immediately force IDLE, s_ready=1, m_valid=0, D=0, b_out=0, ovf=0, counter=0, and clear the captured operands.
REQ-030 Reset in BUSY or DONE SHALL discard the operation with no m_valid pulse.
REQ-031 After rstn deasserts, the first rising edge with s_valid=1 SHALL be accepted normally.

Verification (N=8)
REQ-032 A=5, B=10, b_in=0 -> after 8 cycles D=251 (0xFB), b_out=1, ovf=0; m_valid exactly at edge k+8.
REQ-033 A=30, B=0xF6 (-10), b_in=0 -> D=40, b_out=1, ovf=0; A=5, B=10, b_in=1 -> D=250, b_out=1, ovf=0.
REQ-034 A=127, B=0xFF (-1) -> D=0x80, ovf=1, b_out=1; A=0x80, B=1 -> D=0x7F, ovf=1, b_out=0.
REQ-035 m_ready held 0 for 5 cycles in DONE -> m_valid and D stable throughout; s_valid pulses in that time are not accepted; transfer on the first m_ready=1 edge.
REQ-036 rstn low during the 3rd BUSY cycle -> all outputs at reset values immediately, no m_valid; the next operation after release gives the correct result.
REQ-037 Run 1000 random A, B, b_in with random m_ready backpressure; compare against the model D=(A-B-b_in) mod 256, and check b_out and ovf per REQ-012/026.

Source files
------------

// File: rtl/n_subtractor_serial.sv
// Bit-serial N-bit subtractor with borrow chain, LSB first, one bit per cycle.
// Valid/ready operand intake and result delivery around an IDLE/BUSY/DONE FSM.
module n_subtractor_serial #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         b_in,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [N-1:0] D,
  output logic         b_out,
  output logic         ovf
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [N-1:0]   sh_q, sh_d;
  logic [N-1:0]   d_q, d_d;
  logic           bw_q, bw_d;
  logic           bo_q, bo_d;
  logic           ov_q, ov_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic a_bit, b_bit, d_bit, bw_nx, last;

  assign a_bit = a_q[cnt_q];
  assign b_bit = b_q[cnt_q];
  assign d_bit = a_bit ^ b_bit ^ bw_q;
  assign bw_nx = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bw_q);
  assign last  = (cnt_q == CW'(N - 1));

  assign s_ready = (state_q == IDLE);
  assign m_valid = (state_q == DONE);
  assign D       = d_q;
  assign b_out   = bo_q;
  assign ovf     = ov_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sh_d    = sh_q;
    d_d     = d_q;
    bw_d    = bw_q;
    bo_d    = bo_q;
    ov_d    = ov_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (s_valid) begin
          a_d     = A;
          b_d     = B;
          bw_d    = b_in;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        sh_d = {d_bit, sh_q[N-1:1]};
        bw_d = bw_nx;
        if (last) begin
          // Publish only once complete so D holds the old result meanwhile
          d_d     = {d_bit, sh_q[N-1:1]};
          bo_d    = bw_nx;
          ov_d    = (a_q[N-1] != b_q[N-1]) && (d_bit != a_q[N-1]);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (m_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      d_q     <= '0;
      bw_q    <= 1'b0;
      bo_q    <= 1'b0;
      ov_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sh_q    <= sh_d;
      d_q     <= d_d;
      bw_q    <= bw_d;
      bo_q    <= bo_d;
      ov_q    <= ov_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_n_subtractor_serial.sv
// Self-checking bench for n_subtractor_serial (N=8).
// Directed vectors, backpressure, mid-op reset and random traffic vs model.
module tb_n_subtractor_serial;

  localparam int N = 8;

  logic         clk;
  logic         rstn;
  logic         s_valid;
  logic         s_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         b_in;
  logic         m_valid;
  logic         m_ready;
  logic [N-1:0] D;
  logic         b_out;
  logic         ovf;

  int checks;
  int failures;

  n_subtractor_serial #(.N(N)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .A       (A),
    .B       (B),
    .b_in    (b_in),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .D       (D),
    .b_out   (b_out),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic
  function automatic logic [N+1:0] model(input int a, input int b, input int bi);
    int ud, sa, sb, sd;
    logic [N-1:0] dm;
    logic bo, ov;
    ud = a - b - bi;
    dm = N'(ud);
    bo = (a < b + bi);
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    sd = sa - sb - bi;
    ov = (sd > 127) || (sd < -128);
    return {dm, bo, ov};
  endfunction

  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic bi);
    @(negedge clk);
    A = a;
    B = b;
    b_in = bi;
    s_valid = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    A = N'($urandom);
    B = N'($urandom);
    b_in = 1'($urandom);
  endtask

  task automatic wait_done(input bit rnd_ready, output int cyc);
    cyc = 0;
    while (!m_valid && cyc < 50) begin
      @(negedge clk);
      m_ready = rnd_ready ? 1'($urandom) : 1'b0;
      A = N'($urandom);
      B = N'($urandom);
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    s_valid = 0; A = 0; B = 0; b_in = 0; m_ready = 0;
    rstn = 1'b0;
    #1;
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 || D !== '0 ||
        b_out !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset: s_ready=%b m_valid=%b D=%h b_out=%b ovf=%b want 1 0 00 0 0",
               s_ready, m_valid, D, b_out, ovf);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_directed();
    logic [N-1:0] ta [5] = '{8'd5, 8'd30, 8'd5, 8'd127, 8'h80};
    logic [N-1:0] tb [5] = '{8'd10, 8'hF6, 8'd10, 8'hFF, 8'd1};
    logic         ti [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [N-1:0] ed [5] = '{8'hFB, 8'd40, 8'd250, 8'h80, 8'h7F};
    logic         eb [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic         eo [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int cyc;
    for (int i = 0; i < 5; i++) begin
      send(ta[i], tb[i], ti[i]);
      wait_done(1'b0, cyc);
      checks++;
      if (cyc !== N) begin
        failures++;
        $display("FAIL latency[%0d]: got %0d cycles want %0d", i, cyc, N);
      end
      checks++;
      if (D !== ed[i] || b_out !== eb[i] || ovf !== eo[i]) begin
        failures++;
        $display("FAIL directed[%0d]: D=%h b_out=%b ovf=%b want %h %b %b",
                 i, D, b_out, ovf, ed[i], eb[i], eo[i]);
      end
      handshake();
      checks++;
      if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
        failures++;
        $display("FAIL xfer[%0d]: m_valid=%b s_ready=%b want 0 1",
                 i, m_valid, s_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    send(8'd200, 8'd55, 1'b1);
    wait_done(1'b0, cyc);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      m_ready = 1'b0;
      s_valid = 1'($urandom_range(0, 1));
      A = 8'd1;
      B = 8'd2;
      @(posedge clk);
      #1;
      checks++;
      if (m_valid !== 1'b1 || s_ready !== 1'b0 || D !== 8'd144 ||
          b_out !== 1'b0 || ovf !== 1'b0) begin
        failures++;
        $display("FAIL hold[%0d]: m_valid=%b s_ready=%b D=%h b_out=%b ovf=%b want 1 0 90 0 0",
                 i, m_valid, s_ready, D, b_out, ovf);
      end
    end
    s_valid = 1'b0;
    handshake();
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_xfer: m_valid=%b s_ready=%b want 0 1", m_valid, s_ready);
    end
    // Nothing was accepted during the stall: stays idle
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_idle: m_valid=%b s_ready=%b want 0 1", m_valid, s_ready);
    end
  endtask

  task automatic test_reset_busy();
    int cyc;
    logic saw;
    send(8'd9, 8'd3, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 || D !== '0 ||
        b_out !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL busy_reset: s_ready=%b m_valid=%b D=%h b_out=%b ovf=%b want 1 0 00 0 0",
               s_ready, m_valid, D, b_out, ovf);
    end
    saw = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (m_valid) saw = 1'b1;
    end
    checks++;
    if (saw !== 1'b0) begin
      failures++;
      $display("FAIL busy_reset_mvalid: saw m_valid=%b want 0", saw);
    end
    @(negedge clk);
    rstn = 1'b1;
    send(8'd3, 8'd9, 1'b0);
    wait_done(1'b0, cyc);
    checks++;
    if (cyc !== N || D !== 8'hFA || b_out !== 1'b1 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL after_reset: cyc=%0d D=%h b_out=%b ovf=%b want %0d fa 1 0",
               cyc, D, b_out, ovf, N);
    end
    handshake();
  endtask

  task automatic test_random();
    int cyc, tries;
    logic [N+1:0] exp;
    logic [N-1:0] ra, rb, hd;
    logic ri, done;
    for (int i = 0; i < 1000; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      ri = 1'($urandom);
      if (i < 4) begin
        ra = (i < 2) ? 8'h00 : 8'hFF;
        rb = (i[0]) ? 8'hFF : 8'h00;
      end
      exp = model(int'(ra), int'(rb), int'(ri));
      send(ra, rb, ri);
      wait_done(1'b1, cyc);
      checks++;
      if (cyc !== N || D !== exp[N+1:2] || b_out !== exp[1] || ovf !== exp[0]) begin
        failures++;
        $display("FAIL rand[%0d] A=%h B=%h bi=%b: cyc=%0d D=%h b_out=%b ovf=%b want %0d %h %b %b",
                 i, ra, rb, ri, cyc, D, b_out, ovf, N, exp[N+1:2], exp[1], exp[0]);
      end
      hd = D;
      done = 1'b0;
      tries = 0;
      while (!done) begin
        @(negedge clk);
        m_ready = (tries > 6) ? 1'b1 : 1'($urandom);
        @(posedge clk);
        #1;
        tries++;
        if (m_ready) begin
          done = 1'b1;
          checks++;
          if (m_valid !== 1'b0) begin
            failures++;
            $display("FAIL rand_xfer[%0d]: m_valid=%b want 0", i, m_valid);
          end
        end else begin
          checks++;
          if (m_valid !== 1'b1 || D !== hd) begin
            failures++;
            $display("FAIL rand_hold[%0d]: m_valid=%b D=%h want 1 %h",
                     i, m_valid, D, hd);
          end
        end
      end
      m_ready = 1'($urandom);
    end
    m_ready = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_busy();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
